pe_result_drain: RTL

PE_RESULT_DRAIN -- requirements
Module: pe_result_drain

---
 rtl/pe_result_drain.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pe_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : pe_result_drain
// Purpose  : Two-entry ping-pong buffer between the PE array rounder and a
//            row-wide valid/ready consumer. Each captured block holds two
//            result rows and a round tag. Rows drain as row 0 then row 1.
//            A block arriving when both entries are held is dropped and
//            recorded in a sticky flag and a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module pe_result_drain #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0][LANES-1:0][DATA_W-1:0]   pe_array_out_i,
  input  logic                                rounder_valid_i,
  input  logic [3:0]                          round_number_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [LANES*DATA_W-1:0]             out_data_o,
  output logic [4:0]                          out_row_o,
  output logic [1:0]                          occupancy_o,
  output logic                                overflow_o,
  output logic [7:0]                          drop_cnt_o,
  input  logic                                overflow_clr_i
);

  localparam logic [1:0] c_OCC_FULL = 2'd2;
  localparam logic [7:0] c_CNT_MAX  = 8'hFF;

  // Block storage: data is not reset, it is only visible through valid gating.
  logic [1:0][LANES-1:0][DATA_W-1:0] r_buf [2];
  logic [3:0]                        r_tag [2];

  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic       r_row_sel;
  logic [1:0] r_occ;
  logic       r_ovf;
  logic [7:0] r_drop_cnt;

  logic w_valid;
  logic w_xfer;
  logic w_free;
  logic w_cap;
  logic w_drop;

  // Handshake and capture decisions; a final-row transfer frees room for a
  // same-edge capture even when both entries are held.
  always_comb begin
    w_valid = (r_occ != 2'd0);
    w_xfer  = w_valid & out_ready_i;
    w_free  = w_xfer & r_row_sel;
    w_cap   = rounder_valid_i & ((r_occ != c_OCC_FULL) | w_free);
    w_drop  = rounder_valid_i & ~w_cap;
  end

  // Write the incoming block into the entry addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_buf[r_wr_ptr] <= pe_array_out_i;
      r_tag[r_wr_ptr] <= round_number_i;
    end
  end

  // Pointers, row select and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_row_sel <= 1'b0;
      r_occ     <= 2'd0;
    end else begin
      if (w_cap) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_free) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_xfer) begin
        r_row_sel <= ~r_row_sel;
      end
      case ({w_cap, w_free})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a same-edge drop wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (overflow_clr_i) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != c_CNT_MAX) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (overflow_clr_i) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end
  end

  // Presented row, forced to zero whenever nothing is buffered.
  always_comb begin
    out_valid_o = w_valid;
    out_data_o  = '0;
    out_row_o   = 5'd0;
    if (w_valid) begin
      out_data_o = r_buf[r_rd_ptr][r_row_sel];
      out_row_o  = {r_tag[r_rd_ptr], r_row_sel};
    end
  end

  assign occupancy_o = r_occ;
  assign overflow_o  = r_ovf;
  assign drop_cnt_o  = r_drop_cnt;

endmodule
`default_nettype wire
